// File: rtl/easyaxi_slv_rd.sv
// EasyAXI read-channel responder. AR requests queue in a small in-order
// FIFO; R bursts (FIXED/INCR/WRAP) are served from a word-addressed memory
// that is preloaded to mem[k]=k on reset and writable through a backdoor port.

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_slv_rd #(
  parameter int OST_DEPTH = 4,
  parameter int MEM_WORDS = 256,
  parameter int MEM_AW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_we,
  input  logic [MEM_AW-1:0]        mem_waddr,
  input  logic [`AXI_DATA_W-1:0]   mem_wdata,
  input  logic                     axi_slv_arvalid,
  output logic                     axi_slv_arready,
  input  logic [`AXI_ID_W-1:0]     axi_slv_arid,
  input  logic [`AXI_ADDR_W-1:0]   axi_slv_araddr,
  input  logic [`AXI_LEN_W-1:0]    axi_slv_arlen,
  input  logic [`AXI_SIZE_W-1:0]   axi_slv_arsize,
  input  logic [`AXI_BURST_W-1:0]  axi_slv_arburst,
  output logic                     axi_slv_rvalid,
  input  logic                     axi_slv_rready,
  output logic [`AXI_ID_W-1:0]     axi_slv_rid,
  output logic [`AXI_DATA_W-1:0]   axi_slv_rdata,
  output logic [`AXI_RESP_W-1:0]   axi_slv_rresp,
  output logic                     axi_slv_rlast
);

  localparam int IW       = `AXI_ID_W;
  localparam int AW       = `AXI_ADDR_W;
  localparam int DW       = `AXI_DATA_W;
  localparam int LW       = `AXI_LEN_W;
  localparam int SW       = `AXI_SIZE_W;
  localparam int BW       = `AXI_BURST_W;
  localparam int RW       = `AXI_RESP_W;
  localparam int PW       = $clog2(OST_DEPTH);
  localparam int CW       = PW + 1;
  localparam int WORD_LSB = $clog2(DW / 8);
  localparam logic [CW-1:0] FULL_CNT = CW'(OST_DEPTH);

  typedef enum logic {IDLE, DATA} state_t;

  // Whole-burst protocol errors: reserved burst type, beat wider than the
  // data bus, or a WRAP whose beat count is not 2/4/8/16.
  function automatic logic burst_err(input logic [LW-1:0] len,
                                     input logic [SW-1:0] size,
                                     input logic [BW-1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == BW'(2)) &&
               !((len == LW'(1)) || (len == LW'(3)) ||
                 (len == LW'(7)) || (len == LW'(15)));
    return (burst == BW'(3)) || (size > SW'(WORD_LSB)) || bad_wrap;
  endfunction

  // Address of the beat following addr. INCR aligns to the beat size before
  // stepping (so an unaligned start realigns on beat 2); WRAP folds back to
  // the burst-sized boundary once the step reaches its upper edge.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr,
                                              input logic [LW-1:0] len,
                                              input logic [SW-1:0] size,
                                              input logic [BW-1:0] burst);
    logic [AW-1:0] bytes;
    logic [AW-1:0] total;
    logic [AW-1:0] bound;
    logic [AW-1:0] incr;
    bytes = AW'(1) << size;
    total = bytes * (AW'(len) + AW'(1));
    bound = addr & ~(total - AW'(1));
    incr  = (addr & ~(bytes - AW'(1))) + bytes;
    case (burst)
      BW'(0):  return addr;
      BW'(2):  return (incr == (bound + total)) ? bound : incr;
      default: return incr;
    endcase
  endfunction

  logic [DW-1:0] mem [MEM_WORDS];

  logic [IW-1:0] q_id    [OST_DEPTH];
  logic [AW-1:0] q_addr  [OST_DEPTH];
  logic [LW-1:0] q_len   [OST_DEPTH];
  logic [SW-1:0] q_size  [OST_DEPTH];
  logic [BW-1:0] q_burst [OST_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] queued;

  state_t        state;
  logic [AW-1:0] cur_addr;
  logic [LW-1:0] cur_len;
  logic [LW-1:0] cur_cnt;
  logic [SW-1:0] cur_size;
  logic [BW-1:0] cur_burst;
  logic          cur_err;

  logic          push;
  logic          start;
  logic          advance;
  logic          slot_free;
  logic [AW-1:0] beat_addr;
  logic [AW-1:0] word_idx;
  logic          beat_err;
  logic [DW-1:0] beat_data;
  logic [RW-1:0] beat_resp;

  // A FIFO slot stays occupied until its burst's last beat is accepted, so
  // arready reflects the burst in flight as well as the queued requests.
  assign axi_slv_arready = (cnt != FULL_CNT);
  assign push      = axi_slv_arvalid && axi_slv_arready;
  assign queued    = cnt - CW'(state == DATA);
  assign start     = (state == IDLE) && (queued != '0);
  assign advance   = (state == DATA) && axi_slv_rready && !axi_slv_rlast;
  assign slot_free = (state == DATA) && axi_slv_rready && axi_slv_rlast;

  // Memory: reset preload to the word index, backdoor write otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MEM_WORDS; k++) mem[k] <= DW'(k);
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // AR FIFO storage, written on every accepted request.
  always_ff @(posedge clk) begin
    if (push) begin
      q_id[wr_ptr]    <= axi_slv_arid;
      q_addr[wr_ptr]  <= axi_slv_araddr;
      q_len[wr_ptr]   <= axi_slv_arlen;
      q_size[wr_ptr]  <= axi_slv_arsize;
      q_burst[wr_ptr] <= axi_slv_arburst;
    end
  end

  // AR FIFO pointers and occupancy; the read pointer moves when a burst
  // starts, the occupancy drops when that burst finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (start) rd_ptr <= rd_ptr + PW'(1);
      case ({push, slot_free})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Beat lookup: first beat from the FIFO head, later beats from the next
  // address of the working burst.
  always_comb begin
    beat_addr = next_addr(cur_addr, cur_len, cur_size, cur_burst);
    beat_err  = cur_err;
    if (state == IDLE) begin
      beat_addr = q_addr[rd_ptr];
      beat_err  = burst_err(q_len[rd_ptr], q_size[rd_ptr], q_burst[rd_ptr]);
    end
    word_idx  = beat_addr >> WORD_LSB;
    beat_data = '0;
    beat_resp = RW'(0);
    if (beat_err) begin
      beat_resp = RW'(2);
    end else if (word_idx >= AW'(MEM_WORDS)) begin
      beat_resp = RW'(3);
    end else begin
      beat_data = mem[word_idx[MEM_AW-1:0]];
    end
  end

  // Working registers of the burst being returned.
  always_ff @(posedge clk) begin
    if (start) begin
      cur_addr  <= q_addr[rd_ptr];
      cur_len   <= q_len[rd_ptr];
      cur_cnt   <= q_len[rd_ptr];
      cur_size  <= q_size[rd_ptr];
      cur_burst <= q_burst[rd_ptr];
      cur_err   <= beat_err;
    end else if (advance) begin
      cur_addr  <= beat_addr;
      cur_cnt   <= cur_cnt - LW'(1);
    end
  end

  // R FSM with registered channel outputs, held while the master stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      axi_slv_rvalid <= 1'b0;
      axi_slv_rid    <= '0;
      axi_slv_rdata  <= '0;
      axi_slv_rresp  <= '0;
      axi_slv_rlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state          <= DATA;
            axi_slv_rvalid <= 1'b1;
            axi_slv_rid    <= q_id[rd_ptr];
            axi_slv_rdata  <= beat_data;
            axi_slv_rresp  <= beat_resp;
            axi_slv_rlast  <= (q_len[rd_ptr] == '0);
          end
        end
        DATA: begin
          if (axi_slv_rready) begin
            if (axi_slv_rlast) begin
              state          <= IDLE;
              axi_slv_rvalid <= 1'b0;
            end else begin
              axi_slv_rdata  <= beat_data;
              axi_slv_rresp  <= beat_resp;
              axi_slv_rlast  <= (cur_cnt == LW'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
